// File: rtl/simd_exec_pipe.sv
// simd_exec_pipe: NUM_LANES-wide SIMD ALU with a two-stage valid/ready pipeline,
// an optional carry-chained wide mode and an internal carry register that lets
// back-to-back operations build multi-word arithmetic.
module simd_exec_pipe #(
    parameter int NUM_LANES  = 8,
    parameter int LANE_WIDTH = 8,
    parameter int BITS_ALUOP = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inValid,
    output logic                             inReady,
    input  logic [BITS_ALUOP-1:0]            opCode,
    input  logic                             chainMode,
    input  logic                             selCarry,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]  arrayA,
    input  logic [NUM_LANES*LANE_WIDTH-1:0]  arrayB,
    input  logic [NUM_LANES-1:0]             auxCarry,
    output logic                             outValid,
    input  logic                             outReady,
    output logic [NUM_LANES*LANE_WIDTH-1:0]  executionResult,
    output logic [NUM_LANES-1:0]             carryTotal
);

    localparam int N  = NUM_LANES;
    localparam int W  = LANE_WIDTH;
    localparam int TW = NUM_LANES * LANE_WIDTH;

    localparam logic [BITS_ALUOP-1:0] OP_ADD = BITS_ALUOP'(0);
    localparam logic [BITS_ALUOP-1:0] OP_ADC = BITS_ALUOP'(1);
    localparam logic [BITS_ALUOP-1:0] OP_SUB = BITS_ALUOP'(2);
    localparam logic [BITS_ALUOP-1:0] OP_SBB = BITS_ALUOP'(3);
    localparam logic [BITS_ALUOP-1:0] OP_AND = BITS_ALUOP'(4);
    localparam logic [BITS_ALUOP-1:0] OP_OR  = BITS_ALUOP'(5);
    localparam logic [BITS_ALUOP-1:0] OP_XOR = BITS_ALUOP'(6);
    localparam logic [BITS_ALUOP-1:0] OP_NOT = BITS_ALUOP'(7);
    localparam logic [BITS_ALUOP-1:0] OP_SHL = BITS_ALUOP'(8);
    localparam logic [BITS_ALUOP-1:0] OP_SHR = BITS_ALUOP'(9);

    // One lane: returns {carry_out, result}; cin is already resolved by the caller.
    function automatic logic [W:0] lane_alu(input logic [BITS_ALUOP-1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic         cin);
        logic [W:0] r;
        r = {1'b0, a};
        case (op)
            OP_ADD, OP_ADC: r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            OP_SUB, OP_SBB: r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
            OP_AND:         r = {1'b0, a & b};
            OP_OR:          r = {1'b0, a | b};
            OP_XOR:         r = {1'b0, a ^ b};
            OP_NOT:         r = {1'b0, ~a};
            OP_SHL:         r = {a[W-1], a[W-2:0], cin};
            OP_SHR:         r = {a[0], cin, a[W-1:1]};
            default:        r = {1'b0, a};
        endcase
        return r;
    endfunction

    logic                  vld_p1;
    logic [BITS_ALUOP-1:0] op_p1;
    logic                  chain_p1;
    logic                  sel_p1;
    logic [TW-1:0]         a_p1;
    logic [TW-1:0]         b_p1;
    logic [N-1:0]          aux_p1;

    logic [N-1:0]  carry_reg;
    logic [N-1:0]  carry_src;
    logic [TW-1:0] a_up;
    logic [TW-1:0] res_c;
    logic [N-1:0]  cout_c;
    logic [N-1:0]  carry_reg_next;
    logic          s2_free;
    logic          advance;
    logic          accept;

    assign s2_free = !outValid || outReady;
    assign advance = vld_p1 && s2_free;
    assign inReady = !reset && (!vld_p1 || s2_free);
    assign accept  = inValid && inReady;

    assign carry_src = sel_p1 ? carry_reg : auxCarry_p1_unused_guard();
    // Helper keeps the carry source selection readable (aux bits come from stage 1).
    function automatic logic [N-1:0] auxCarry_p1_unused_guard();
        return aux_p1;
    endfunction

    // Lane i+1's bit 0 lines up with lane i's shift-in position for chained SHR.
    assign a_up = a_p1 >> W;

    // Resolve each lane's carry-in and evaluate all lanes; ripple is the carry
    // out of the previous lane when the lanes are fused into one wide word.
    always_comb begin
        logic       cin;
        logic       ripple;
        logic [W:0] lane;
        res_c  = '0;
        cout_c = '0;
        ripple = 1'b0;
        for (int i = 0; i < N; i++) begin
            cin = carry_src[i];
            if (!chain_p1 || i == 0) begin
                if (op_p1 == OP_ADD)      cin = 1'b0;
                else if (op_p1 == OP_SUB) cin = 1'b1;
            end else begin
                cin = ripple;
            end
            if (chain_p1 && op_p1 == OP_SHR)
                cin = (i == N - 1) ? carry_src[N-1] : a_up[i*W];
            lane = lane_alu(op_p1, a_p1[i*W +: W], b_p1[i*W +: W], cin);
            res_c[i*W +: W] = lane[W-1:0];
            cout_c[i]       = lane[W];
            ripple          = lane[W];
        end
        carry_reg_next = chain_p1 ? {{(N-1){1'b0}}, cout_c[N-1]} : cout_c;
    end

    // Stage 1 control: occupancy of the input register.
    always_ff @(posedge clk) begin
        if (reset)        vld_p1 <= 1'b0;
        else if (accept)  vld_p1 <= 1'b1;
        else if (advance) vld_p1 <= 1'b0;
    end

    // Stage 1 data: capture the operand bundle on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1    <= opCode;
            chain_p1 <= chainMode;
            sel_p1   <= selCarry;
            a_p1     <= arrayA;
            b_p1     <= arrayB;
            aux_p1   <= auxCarry;
        end
    end

    // Stage 2: register result and carries on transfer, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid        <= 1'b0;
            executionResult <= '0;
            carryTotal      <= '0;
            carry_reg       <= '0;
        end else if (advance) begin
            outValid        <= 1'b1;
            executionResult <= res_c;
            carryTotal      <= cout_c;
            carry_reg       <= carry_reg_next;
        end else if (outReady) begin
            outValid        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simd_exec_pipe.sv
// tb_simd_exec_pipe: directed test-plan cases plus randomized traffic, checked
// every cycle against a wide-arithmetic reference model with an ordered queue.
module tb_simd_exec_pipe;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int TW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic [3:0]    opCode;
    logic          chainMode;
    logic          selCarry;
    logic [TW-1:0] arrayA;
    logic [TW-1:0] arrayB;
    logic [N-1:0]  auxCarry;
    logic          outValid;
    logic          outReady;
    logic [TW-1:0] executionResult;
    logic [N-1:0]  carryTotal;

    always #5 clk = ~clk;

    simd_exec_pipe #(.NUM_LANES(N), .LANE_WIDTH(W), .BITS_ALUOP(4)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .opCode(opCode), .chainMode(chainMode), .selCarry(selCarry),
        .arrayA(arrayA), .arrayB(arrayB), .auxCarry(auxCarry),
        .outValid(outValid), .outReady(outReady),
        .executionResult(executionResult), .carryTotal(carryTotal)
    );

    typedef struct packed {
        logic [3:0]    op;
        logic          chain;
        logic          sel;
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic [N-1:0]  aux;
    } bundle_t;

    typedef struct packed {
        logic [TW-1:0] r;
        logic [N-1:0]  c;
    } res_t;

    bundle_t q_in[$];
    res_t    q_out[$];
    res_t    got[$];
    int      got_cyc[$];
    logic [N-1:0] mcarry = '0;
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit rst_prev   = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: chained add/sub as one 64-bit sum, lane carries from prefix sums;
    // chained shifts as whole-word shifts; everything else lane by lane.
    function automatic void model(input bundle_t bd, input logic [N-1:0] s,
                                  output logic [TW-1:0] r, output logic [N-1:0] c);
        logic [64:0] part;
        logic [63:0] bb;
        logic [63:0] mask;
        logic        c0;
        logic [7:0]  al, bl;
        logic [8:0]  lr;
        logic        ci;
        r = '0;
        c = '0;
        if (bd.chain && bd.op <= 4'd3) begin
            bb = (bd.op >= 4'd2) ? ~bd.b : bd.b;
            c0 = (bd.op == 4'd0) ? 1'b0 : (bd.op == 4'd2) ? 1'b1 : s[0];
            part = {1'b0, bd.a} + {1'b0, bb} + 65'(c0);
            r = part[63:0];
            for (int i = 0; i < N; i++) begin
                mask = (i == N - 1) ? {64{1'b1}} : ((64'd1 << (8 * (i + 1))) - 64'd1);
                part = {1'b0, bd.a & mask} + {1'b0, bb & mask} + 65'(c0);
                c[i] = part[8 * (i + 1)];
            end
        end else if (bd.chain && bd.op == 4'd8) begin
            r = {bd.a[62:0], s[0]};
            for (int i = 0; i < N; i++) c[i] = bd.a[8 * i + 7];
        end else if (bd.chain && bd.op == 4'd9) begin
            r = {s[N-1], bd.a[63:1]};
            for (int i = 0; i < N; i++) c[i] = bd.a[8 * i];
        end else begin
            for (int i = 0; i < N; i++) begin
                al = bd.a[8 * i +: 8];
                bl = bd.b[8 * i +: 8];
                ci = s[i];
                case (bd.op)
                    4'd0:    lr = {1'b0, al} + {1'b0, bl};
                    4'd1:    lr = {1'b0, al} + {1'b0, bl} + 9'(ci);
                    4'd2:    lr = {1'b0, al} + {1'b0, ~bl} + 9'd1;
                    4'd3:    lr = {1'b0, al} + {1'b0, ~bl} + 9'(ci);
                    4'd4:    lr = {1'b0, al & bl};
                    4'd5:    lr = {1'b0, al | bl};
                    4'd6:    lr = {1'b0, al ^ bl};
                    4'd7:    lr = {1'b0, ~al};
                    4'd8:    lr = {al, ci};
                    4'd9:    lr = {al[0], ci, al[7:1]};
                    default: lr = {1'b0, al};
                endcase
                r[8 * i +: 8] = lr[7:0];
                c[i] = lr[8];
            end
        end
    endfunction

    always @(posedge clk) cyc++;

    bundle_t      nb;
    logic [TW-1:0] er;
    logic [N-1:0]  ec;
    logic [N-1:0]  sv;
    bit            exp_ov;
    bit            exp_rdy;
    bit            s2free;

    // Compare process: every cycle, then advance the reference for the coming edge.
    always @(negedge clk) begin
        if (rst_prev) begin
            chk("rst_outValid", {63'd0, outValid}, 64'd0);
            chk("rst_result", executionResult, 64'd0);
            chk("rst_carry", {56'd0, carryTotal}, 64'd0);
        end else begin
            exp_ov = (q_out.size() > 0);
            chk("outValid", {63'd0, outValid}, {63'd0, exp_ov});
            if (exp_ov) begin
                chk("result", executionResult, q_out[0].r);
                chk("carryTotal", {56'd0, carryTotal}, {56'd0, q_out[0].c});
            end
        end
        exp_rdy = !reset && !((q_in.size() > 0) && (q_out.size() > 0) && !outReady);
        chk("inReady", {63'd0, inReady}, {63'd0, exp_rdy});
        if (reset) begin
            q_in.delete();
            q_out.delete();
            mcarry = '0;
        end else begin
            s2free = (q_out.size() == 0) || outReady;
            if (outValid && outReady && !rst_prev) begin
                got.push_back('{executionResult, carryTotal});
                got_cyc.push_back(cyc);
            end
            if (q_out.size() > 0 && outReady) void'(q_out.pop_front());
            if (s2free && q_in.size() > 0) begin
                nb = q_in.pop_front();
                sv = nb.sel ? mcarry : nb.aux;
                model(nb, sv, er, ec);
                q_out.push_back('{er, ec});
                mcarry = nb.chain ? {{(N-1){1'b0}}, ec[N-1]} : ec;
            end
            if (inValid && inReady)
                q_in.push_back('{opCode, chainMode, selCarry, arrayA, arrayB, auxCarry});
        end
        rst_prev = reset;
    end

    task automatic drive(input logic [3:0] op, input logic ch, input logic sel,
                         input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [N-1:0] aux);
        opCode = op; chainMode = ch; selCarry = sel;
        arrayA = a; arrayB = b; auxCarry = aux;
    endtask

    task automatic send(input logic [3:0] op, input logic ch, input logic sel,
                        input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [N-1:0] aux,
                        output int acc_cyc);
        int k;
        drive(op, ch, sel, a, b, aux);
        inValid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!inReady && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!inReady) chk("send_timeout", 64'd0, 64'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q_in.size() > 0 || q_out.size() > 0) && k < 100) begin
            k++;
            @(posedge clk); #1;
        end
        if (q_in.size() > 0 || q_out.size() > 0) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_got(input string name, input int idx, input logic [TW-1:0] r, input logic [N-1:0] c);
        chk({name, "_present"}, {63'd0, got.size() > idx}, 64'd1);
        if (got.size() > idx) begin
            chk({name, "_result"}, got[idx].r, r);
            chk({name, "_carry"}, {56'd0, got[idx].c}, {56'd0, c});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n, taken, pending;
        bundle_t bp[4];
        logic [TW-1:0] mr;
        logic [N-1:0]  mc;

        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        drive(4'd0, 1'b0, 1'b0, '0, '0, '0);

        // Pin the reference model with hand-computed values.
        model('{4'd0, 1'b1, 1'b0, 64'h00FF_FFFF_FFFF_FFFF, 64'h1, 8'h00}, 8'h00, mr, mc);
        chk("model_chain_add_r", mr, 64'h0100_0000_0000_0000);
        chk("model_chain_add_c", {56'd0, mc}, 64'h7F);
        model('{4'd9, 1'b1, 1'b0, 64'h0100, 64'h0, 8'h80}, 8'h80, mr, mc);
        chk("model_chain_shr_r", mr, 64'h8000_0000_0000_0080);
        chk("model_chain_shr_c", {56'd0, mc}, 64'h02);
        model('{4'd2, 1'b0, 1'b0, {8{8'h05}}, {8{8'h07}}, 8'h00}, 8'h00, mr, mc);
        chk("model_sub_r", mr, {8{8'hFE}});
        chk("model_sub_c", {56'd0, mc}, 64'h00);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Independent ADD with lane-0 overflow; latency 2.
        n = got.size();
        send(4'd0, 1'b0, 1'b0, 64'h1010_1010_1010_10FF, 64'h2020_2020_2020_2001, 8'h00, acc);
        drain();
        chk_got("t1_add", n, 64'h3030_3030_3030_3000, 8'h01);
        if (got_cyc.size() > n) chk("t1_latency", 64'(got_cyc[n] - acc), 64'd2);

        // Chained ADD ripple across seven lanes.
        n = got.size();
        send(4'd0, 1'b1, 1'b0, 64'h00FF_FFFF_FFFF_FFFF, 64'h1, 8'h00, acc);
        drain();
        chk_got("t2_chain_add", n, 64'h0100_0000_0000_0000, 8'h7F);

        // Multi-word: carry out of a chained ADD feeds the next ADC back-to-back.
        n = got.size();
        send(4'd0, 1'b1, 1'b0, {64{1'b1}}, 64'h1, 8'h00, acc);
        send(4'd1, 1'b1, 1'b1, 64'h0, 64'h0, 8'h00, acc);
        drain();
        chk_got("t3_add", n, 64'h0, 8'hFF);
        chk_got("t3_adc", n + 1, 64'h1, 8'h00);

        // Independent SUB with borrow, then chained SHR with aux shift-in.
        n = got.size();
        send(4'd2, 1'b0, 1'b0, {8{8'h05}}, {8{8'h07}}, 8'h00, acc);
        send(4'd9, 1'b1, 1'b0, 64'h0100, 64'h0, 8'h80, acc);
        drain();
        chk_got("t4_sub", n, {8{8'hFE}}, 8'h00);
        chk_got("t4_shr", n + 1, 64'h8000_0000_0000_0080, 8'h02);

        // Backpressure: four bundles offered over four stalled cycles.
        n = got.size();
        for (int i = 0; i < 4; i++)
            bp[i] = '{4'($urandom_range(0, 6)), 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom)};
        outReady = 1'b0;
        pending = 0;
        for (int c = 0; c < 4; c++) begin
            drive(bp[pending].op, bp[pending].chain, bp[pending].sel, bp[pending].a, bp[pending].b, bp[pending].aux);
            inValid = 1'b1;
            @(negedge clk);
            taken = inReady ? 1 : 0;
            @(posedge clk); #1;
            pending += taken;
        end
        inValid = 1'b0;
        chk("t5_accepted_while_stalled", 64'(pending), 64'd2);
        outReady = 1'b1;
        while (pending < 4) begin
            send(bp[pending].op, bp[pending].chain, bp[pending].sel, bp[pending].a, bp[pending].b, bp[pending].aux, acc);
            pending++;
        end
        drain();
        chk("t5_count_out", 64'(got.size() - n), 64'd4);

        // Reset with two bundles in flight clears carryReg.
        send(4'd0, 1'b0, 1'b0, {64{1'b1}}, {8{8'h01}}, 8'h00, acc);
        send(4'd0, 1'b0, 1'b0, {64{1'b1}}, {8{8'h01}}, 8'h00, acc);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n = got.size();
        send(4'd1, 1'b0, 1'b1, {8{8'h01}}, {8{8'h02}}, 8'h00, acc);
        drain();
        chk_got("t6_adc_after_reset", n, {8{8'h03}}, 8'h00);

        // Randomized traffic with random stalls and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            drive(4'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom));
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; inValid = 1'b0; outReady = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
